// File: rtl/k12a_pkg.sv
// Shared types and constants for the K12A instruction-fetch sequencer.
package k12a_pkg;

    // Fetch sequencer states: idle, high-byte read, low-byte read, PC advance.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_HIGH = 2'd1,
        ST_RD_LOW  = 2'd2,
        ST_DONE    = 2'd3
    } k12a_fetch_state_t;

    // Program counter value after reset.
    localparam logic [15:0] K12A_RESET_VECTOR = 16'h0000;

endpackage

// File: rtl/k12a_fetch_unit_if.sv
// Memory read / instruction-register capture bus between the fetch unit
// (master) and the memory plus instruction registers (slave).
//
// Handshake: while mem_read is high the master holds a stable address on
// addr_bus. The slave raises mem_ready in any cycle in which data_bus carries
// the byte for that address; the master then raises exactly one of
// inst_high_store / inst_low_store in that same cycle, and the instruction
// register captures data_bus at the next rising edge. Without mem_ready the
// master keeps the address and mem_read unchanged (wait state).
interface k12a_fetch_unit_if;
    logic mem_read;
    logic mem_ready;
    logic inst_high_store;
    logic inst_low_store;

    modport master (
        output mem_read,
        output inst_high_store,
        output inst_low_store,
        input  mem_ready
    );

    modport slave (
        input  mem_read,
        input  inst_high_store,
        input  inst_low_store,
        output mem_ready
    );
endinterface

// File: rtl/k12a_fetch_timer.sv
// Wait-state counter for one byte read; flags when the allowed number of
// wait cycles is used up. Only instantiated with K12A_FETCH_TIMEOUT_EN.
module k12a_fetch_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    // Counter restarts whenever a byte read begins and counts its wait cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (tick) begin
            count <= count + 8'd1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/k12a_fetch_unit.sv
// K12A instruction-fetch sequencer. Reads a big-endian 16-bit instruction
// (high byte at PC, low byte at PC+1), strobes the instruction registers and
// advances PC by 2.
// Optional feature macro: K12A_FETCH_TIMEOUT_EN (bounded wait states with a
// fetch_error abort); without it waits are unbounded and fetch_error is 0.
module k12a_fetch_unit
    import k12a_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR = K12A_RESET_VECTOR
`ifdef K12A_FETCH_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
    input  logic                     cpu_clock,
    input  logic                     reset,
    input  logic                     fetch_start,
    input  logic                     pc_load,
    input  logic [15:0]              pc_in,
    inout  wire  [15:0]              addr_bus,
    k12a_fetch_unit_if.master        bus,
    output logic [15:0]              pc,
    output logic                     busy,
    output logic                     fetch_done,
    output logic                     fetch_error,
    output k12a_fetch_state_t        state_dbg
);

    k12a_fetch_state_t state;
    k12a_fetch_state_t state_next;
    logic [15:0]       pc_next;
    logic [15:0]       addr_out;
    logic              addr_oe;
    logic              timer_expired;

`ifdef K12A_FETCH_TIMEOUT_EN
    logic in_read;
    assign in_read = (state == ST_RD_HIGH) || (state == ST_RD_LOW);

    k12a_fetch_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (cpu_clock),
        .rst     (reset),
        .clear   (!in_read || bus.mem_ready),
        .tick    (in_read && !bus.mem_ready),
        .expired (timer_expired)
    );
`else
    assign timer_expired = 1'b0;
`endif

    // State and program counter registers; reset aborts any fetch at once.
    always_ff @(posedge cpu_clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= RESET_VECTOR;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    // Next-state, PC update and bus outputs; strobes follow mem_ready directly
    // so they coincide with the cycle data_bus is valid.
    always_comb begin
        state_next          = state;
        pc_next             = pc;
        addr_out            = pc;
        addr_oe             = 1'b0;
        bus.mem_read        = 1'b0;
        bus.inst_high_store = 1'b0;
        bus.inst_low_store  = 1'b0;
        fetch_done          = 1'b0;
        fetch_error         = 1'b0;
        case (state)
            ST_IDLE: begin
                // A same-edge load is picked up by the following fetch.
                if (pc_load) begin
                    pc_next = pc_in;
                end
                if (fetch_start) begin
                    state_next = ST_RD_HIGH;
                end
            end
            ST_RD_HIGH: begin
                addr_oe             = 1'b1;
                bus.mem_read        = 1'b1;
                bus.inst_high_store = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_next = ST_RD_LOW;
                end else if (timer_expired) begin
                    state_next  = ST_IDLE;
                    fetch_error = 1'b1;
                end
            end
            ST_RD_LOW: begin
                addr_out           = pc + 16'd1;
                addr_oe            = 1'b1;
                bus.mem_read       = 1'b1;
                bus.inst_low_store = bus.mem_ready;
                if (bus.mem_ready) begin
                    state_next = ST_DONE;
                end else if (timer_expired) begin
                    state_next  = ST_IDLE;
                    fetch_error = 1'b1;
                end
            end
            ST_DONE: begin
                fetch_done = 1'b1;
                pc_next    = pc + 16'd2;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign addr_bus  = addr_oe ? addr_out : 16'bz;
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_k12a_fetch_unit.sv
// Self-checking bench for k12a_fetch_unit: byte-addressed memory model,
// instruction register capture, and a per-cycle expected-output queue built
// from the fetch transaction rules.
module tb_k12a_fetch_unit;
    import k12a_pkg::*;

    typedef struct packed {
        logic        mem_read;
        logic        hs;
        logic        ls;
        logic        busy;
        logic        done;
        logic        err;
        logic [15:0] addr;
        logic [15:0] pc;
    } exp_t;

    logic              cpu_clock = 1'b0;
    logic              reset;
    logic              fetch_start;
    logic              pc_load;
    logic [15:0]       pc_in;
    wire  [15:0]       addr_bus;
    logic [15:0]       pc;
    logic              busy;
    logic              fetch_done;
    logic              fetch_error;
    k12a_fetch_state_t state_dbg;

    k12a_fetch_unit_if ifc ();

    logic [7:0]  mem [0:65535];
    logic [7:0]  data_bus;
    logic [15:0] inst_reg = 16'h0000;
    int          low_caps = 0;
    int          done_caps = 0;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [15:0] model_pc;
    int          n_checks = 0;
    int          n_pass = 0;

    k12a_fetch_unit #(
        .RESET_VECTOR(16'h0000)
`ifdef K12A_FETCH_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .cpu_clock   (cpu_clock),
        .reset       (reset),
        .fetch_start (fetch_start),
        .pc_load     (pc_load),
        .pc_in       (pc_in),
        .addr_bus    (addr_bus),
        .bus         (ifc),
        .pc          (pc),
        .busy        (busy),
        .fetch_done  (fetch_done),
        .fetch_error (fetch_error),
        .state_dbg   (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 cpu_clock = ~cpu_clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- memory and instruction registers ----------------
    assign data_bus = ifc.mem_ready ? mem[addr_bus] : 8'h00;

    always @(posedge cpu_clock) begin
        if (ifc.inst_high_store) inst_reg[15:8] <= data_bus;
        if (ifc.inst_low_store)  inst_reg[7:0]  <= data_bus;
        if (ifc.inst_low_store)  low_caps  <= low_caps + 1;
        if (fetch_done)          done_caps <= done_caps + 1;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic exp_t mk(input logic mr, input logic hs, input logic ls,
                                input logic bsy, input logic dn, input logic er,
                                input logic [15:0] addr, input logic [15:0] pcv);
        exp_t e;
        e.mem_read = mr; e.hs = hs; e.ls = ls; e.busy = bsy;
        e.done = dn; e.err = er; e.addr = addr; e.pc = pcv;
        return e;
    endfunction

    // Scoreboard: every queued cycle is compared mid-cycle.
    always @(negedge cpu_clock) begin
        if (!reset && exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("mem_read", 32'(ifc.mem_read), 32'(cur.mem_read));
            chk("inst_high_store", 32'(ifc.inst_high_store), 32'(cur.hs));
            chk("inst_low_store", 32'(ifc.inst_low_store), 32'(cur.ls));
            chk("busy", 32'(busy), 32'(cur.busy));
            chk("fetch_done", 32'(fetch_done), 32'(cur.done));
            chk("fetch_error", 32'(fetch_error), 32'(cur.err));
            chk("pc", 32'(pc), 32'(cur.pc));
            if (cur.mem_read) chk("addr_bus", 32'(addr_bus), 32'(cur.addr));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic fs, input logic pl, input logic [15:0] pin,
                        input logic rdy, input exp_t e);
        fetch_start   = fs;
        pc_load       = pl;
        pc_in         = pin;
        ifc.mem_ready = rdy;
        exp_q.push_back(e);
        @(posedge cpu_clock);
        #1;
    endtask

    // One complete fetch: w_hi/w_lo wait cycles before each byte; noise drives
    // fetch_start/pc_load/mem_ready where they must be ignored.
    task automatic do_fetch(input bit load, input logic [15:0] target,
                            input int w_hi, input int w_lo, input bit noise);
        logic [15:0] p;
        logic [15:0] p1;
        step(1'b1, load, target, noise, mk(0, 0, 0, 0, 0, 0, 16'h0, model_pc));
        if (load) model_pc = target;
        p  = model_pc;
        p1 = p + 16'd1;
        for (int i = 0; i < w_hi; i++)
            step(noise, noise, 16'($urandom), 1'b0, mk(1, 0, 0, 1, 0, 0, p, p));
        step(noise, noise, 16'($urandom), 1'b1, mk(1, 1, 0, 1, 0, 0, p, p));
        for (int i = 0; i < w_lo; i++)
            step(noise, noise, 16'($urandom), 1'b0, mk(1, 0, 0, 1, 0, 0, p1, p));
        step(noise, noise, 16'($urandom), 1'b1, mk(1, 0, 1, 1, 0, 0, p1, p));
        step(noise, noise, 16'($urandom), 1'b1, mk(0, 0, 0, 1, 1, 0, 16'h0, p));
        model_pc = p + 16'd2;
        step(1'b0, 1'b0, 16'h0, 1'b1, mk(0, 0, 0, 0, 0, 0, 16'h0, model_pc));
        chk("inst_reg", 32'(inst_reg), 32'({mem[p], mem[p1]}));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lc;
        int dc;
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
        mem[0] = 8'hA5;
        mem[1] = 8'h3C;

        reset = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; pc_in = 16'h0;
        ifc.mem_ready = 1'b1;
        repeat (2) @(posedge cpu_clock);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_read", 32'(ifc.mem_read), 32'd0);
        chk("reset_strobes", 32'({ifc.inst_high_store, ifc.inst_low_store}), 32'd0);
        chk("reset_done_err", 32'({fetch_done, fetch_error}), 32'd0);
        chk("reset_pc", 32'(pc), 32'h0000);
        chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        reset = 1'b0;
        model_pc = 16'h0000;

        // Basic fetch from the reset vector.
        do_fetch(1'b0, 16'h0, 0, 0, 1'b0);
        chk("t1_pc", 32'(pc), 32'h0002);
        chk("t1_inst", 32'(inst_reg), 32'h0000A53C);

        // Load and fetch on the same edge.
        do_fetch(1'b1, 16'h1234, 0, 0, 1'b0);
        chk("t2_pc", 32'(pc), 32'h1236);

        // Load alone, then fetch across the address wrap.
        step(1'b0, 1'b1, 16'hFFFF, 1'b0, mk(0, 0, 0, 0, 0, 0, 16'h0, model_pc));
        model_pc = 16'hFFFF;
        do_fetch(1'b0, 16'h0, 0, 0, 1'b0);
        chk("t3_pc", 32'(pc), 32'h0001);

        // Wait states with ignored control pulses; odd PC.
        do_fetch(1'b0, 16'h0, 3, 0, 1'b1);
        chk("t4_pc", 32'(pc), 32'h0003);
        do_fetch(1'b0, 16'h0, 1, 2, 1'b1);
        chk("t4b_pc", 32'(pc), 32'h0005);

        // Reset asserted while the low byte is pending.
        step(1'b1, 1'b0, 16'h0, 1'b0, mk(0, 0, 0, 0, 0, 0, 16'h0, model_pc));
        step(1'b0, 1'b0, 16'h0, 1'b1, mk(1, 1, 0, 1, 0, 0, model_pc, model_pc));
        ifc.mem_ready = 1'b0;
        lc = low_caps;
        dc = done_caps;
        #2 reset = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_mem_read", 32'(ifc.mem_read), 32'd0);
        chk("t5_pc", 32'(pc), 32'h0000);
        chk("t5_state", 32'(state_dbg), 32'(ST_IDLE));
        ifc.mem_ready = 1'b1;
        #1;
        chk("t5_low_store", 32'(ifc.inst_low_store), 32'd0);
        @(posedge cpu_clock);
        #1;
        chk("t5_low_caps", 32'(low_caps), 32'(lc));
        chk("t5_done_caps", 32'(done_caps), 32'(dc));
        reset = 1'b0;
        model_pc = 16'h0000;
        do_fetch(1'b0, 16'h0, 0, 0, 1'b0);
        chk("t5_recover_inst", 32'(inst_reg), 32'h0000A53C);

`ifdef K12A_FETCH_TIMEOUT_EN
        // Timeout abort after four high-byte cycles without mem_ready.
        step(1'b1, 1'b0, 16'h0, 1'b0, mk(0, 0, 0, 0, 0, 0, 16'h0, model_pc));
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 16'h0, 1'b0, mk(1, 0, 0, 1, 0, 0, model_pc, model_pc));
        step(1'b0, 1'b0, 16'h0, 1'b0, mk(1, 0, 0, 1, 0, 1, model_pc, model_pc));
        step(1'b0, 1'b0, 16'h0, 1'b0, mk(0, 0, 0, 0, 0, 0, 16'h0, model_pc));
        chk("t6_pc", 32'(pc), 32'h0002);
`else
        // Without the timeout, a long wait still completes normally.
        do_fetch(1'b0, 16'h0, 20, 0, 1'b0);
        chk("t6_pc", 32'(pc), 32'h0004);
`endif

        @(negedge cpu_clock);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
